// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and digit geometry for the guessing-game sequencer
package game_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS = 3;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  typedef enum logic [2:0] {
    SETUP,
    WAIT,
    CMP0,
    CMP1,
    CMP2,
    DONE,
    WIN,
    LOSE
  } state_t;
endpackage

// File: rtl/entry_validator.sv
// entry_validator: flags a keypad entry whose digits are all decimal and pairwise distinct
module entry_validator
  import game_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_d0,
  input  logic [DIGIT_W-1:0] i_d1,
  input  logic [DIGIT_W-1:0] i_d2,
  output logic               o_valid
);
  logic w_range, w_distinct;
  assign w_range    = (i_d0 <= DIGIT_MAX) && (i_d1 <= DIGIT_MAX) && (i_d2 <= DIGIT_MAX);
  assign w_distinct = (i_d0 != i_d1) && (i_d0 != i_d2) && (i_d1 != i_d2);
  assign o_valid    = w_range && w_distinct;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: latches the answer, scores each guess one digit per cycle, tracks tries and win/lose
module game_sequencer
  import game_pkg::*;
#(
  parameter int MAX_TRIES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIGIT_W-1:0]   iNum1,
  input  logic [DIGIT_W-1:0]   iNum2,
  input  logic [DIGIT_W-1:0]   iNum3,
  input  logic                 iNumRdy,
  input  logic                 iNew,
  output logic                 oAnsSet,
  output logic [1:0]           oA,
  output logic [1:0]           oB,
  output logic                 oScoreVld,
  output logic                 oReject,
  output logic [3:0]           oTries,
  output logic                 oBusy,
  output logic                 oWin,
  output logic                 oLose
);
  localparam logic [3:0] TRY_LIM = 4'(MAX_TRIES);
  state_t r_state, w_next;
  logic r_rdy, w_evt, w_take, w_valid, w_a_hit, w_b_hit;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_ans, r_guess, w_in;
  logic [1:0] r_acc_a, r_acc_b, w_idx;
  logic [3:0] w_tries_inc;
  assign w_in        = {iNum3, iNum2, iNum1};
  assign w_evt       = iNumRdy & ~r_rdy;
  assign w_take      = w_evt & ((r_state == SETUP) | (r_state == WAIT));
  assign w_idx       = (r_state == CMP1) ? 2'd1 : (r_state == CMP2) ? 2'd2 : 2'd0;
  assign w_tries_inc = (oTries == 4'hf) ? oTries : oTries + 4'd1;
  assign oBusy       = (r_state == CMP0) | (r_state == CMP1) | (r_state == CMP2) | (r_state == DONE);
  entry_validator u_val (
    .i_d0   (iNum1),
    .i_d1   (iNum2),
    .i_d2   (iNum3),
    .o_valid(w_valid)
  );
  // B only counts when the guessed digit sits at a different answer position
  always_comb begin
    w_a_hit = r_guess[w_idx] == r_ans[w_idx];
    w_b_hit = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j != int'(w_idx) && r_guess[w_idx] == r_ans[j]) w_b_hit = 1'b1;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      SETUP:   w_next = (w_take && w_valid) ? WAIT : SETUP;
      WAIT:    w_next = (w_take && w_valid) ? CMP0 : WAIT;
      CMP0:    w_next = CMP1;
      CMP1:    w_next = CMP2;
      CMP2:    w_next = DONE;
      DONE:    w_next = (r_acc_a == 2'd3) ? WIN : (w_tries_inc == TRY_LIM) ? LOSE : WAIT;
      default: w_next = r_state;
    endcase
    if (iNew) w_next = SETUP;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= SETUP;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy     <= 1'b0;
      r_ans     <= '0;
      r_guess   <= '0;
      r_acc_a   <= 2'd0;
      r_acc_b   <= 2'd0;
      oAnsSet   <= 1'b0;
      oA        <= 2'd0;
      oB        <= 2'd0;
      oScoreVld <= 1'b0;
      oReject   <= 1'b0;
      oTries    <= 4'd0;
      oWin      <= 1'b0;
      oLose     <= 1'b0;
    end else begin
      r_rdy     <= iNumRdy;
      oScoreVld <= 1'b0;
      oReject   <= 1'b0;
      if (iNew) begin
        r_ans   <= '0;
        r_guess <= '0;
        r_acc_a <= 2'd0;
        r_acc_b <= 2'd0;
        oAnsSet <= 1'b0;
        oA      <= 2'd0;
        oB      <= 2'd0;
        oTries  <= 4'd0;
        oWin    <= 1'b0;
        oLose   <= 1'b0;
      end else begin
        oWin  <= r_state == WIN;
        oLose <= r_state == LOSE;
        if (w_take && !w_valid) oReject <= 1'b1;
        if (w_take && w_valid && r_state == SETUP) begin
          r_ans   <= w_in;
          oAnsSet <= 1'b1;
        end
        if (w_take && w_valid && r_state == WAIT) begin
          r_guess <= w_in;
          r_acc_a <= 2'd0;
          r_acc_b <= 2'd0;
        end
        if (r_state == CMP0 || r_state == CMP1 || r_state == CMP2) begin
          r_acc_a <= r_acc_a + {1'b0, w_a_hit};
          r_acc_b <= r_acc_b + {1'b0, ~w_a_hit & w_b_hit};
        end
        if (r_state == DONE) begin
          oA        <= r_acc_a;
          oB        <= r_acc_b;
          oTries    <= w_tries_inc;
          oScoreVld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard bench with a set-based scoring model and randomized games
module tb_game_sequencer;
  localparam int MT = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] iNum1 = '0, iNum2 = '0, iNum3 = '0;
  logic iNumRdy = 1'b0, iNew = 1'b0;
  logic oAnsSet, oScoreVld, oReject, oBusy, oWin, oLose;
  logic [1:0] oA, oB;
  logic [3:0] oTries;
  game_sequencer #(.MAX_TRIES(MT)) dut (
    .clk(clk), .reset(reset), .iNum1(iNum1), .iNum2(iNum2), .iNum3(iNum3),
    .iNumRdy(iNumRdy), .iNew(iNew), .oAnsSet(oAnsSet), .oA(oA), .oB(oB),
    .oScoreVld(oScoreVld), .oReject(oReject), .oTries(oTries), .oBusy(oBusy),
    .oWin(oWin), .oLose(oLose)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  typedef struct {int a; int b; int t; int c;} sc_t;
  sc_t q_sc[$];
  int q_rej[$];
  sc_t mon_e;
  int mon_r;
  int ph, ans[3], m_tries, m_a, m_b;
  bit m_set, m_win, m_lose;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic bit valid3(int d0, int d1, int d2);
    return d0 < 10 && d1 < 10 && d2 < 10 && d0 != d1 && d0 != d2 && d1 != d2;
  endfunction
  function automatic void rand_valid(output int d[3]);
    d[0] = $urandom_range(9);
    do d[1] = $urandom_range(9); while (d[1] == d[0]);
    do d[2] = $urandom_range(9); while (d[2] == d[0] || d[2] == d[1]);
  endfunction
  task automatic ref_clear();
    ph = 0; ans = '{0, 0, 0}; m_tries = 0; m_a = 0; m_b = 0;
    m_set = 0; m_win = 0; m_lose = 0;
  endtask
  task automatic check_outs();
    chk("ansset", oAnsSet, m_set);
    chk("tries", oTries, m_tries);
    chk("held_A", oA, m_a);
    chk("held_B", oB, m_b);
    chk("win", oWin, m_win);
    chk("lose", oLose, m_lose);
  endtask
  // ph: 0 awaiting answer, 1 awaiting guess, 2 game over
  task automatic entry(int d1, int d2, int d3, int hold);
    int c, busy, busy_exp, a, hits, lim;
    int g[3];
    @(negedge clk);
    iNum1 = 4'(d1); iNum2 = 4'(d2); iNum3 = 4'(d3); iNumRdy = 1'b1;
    c = cyc; busy_exp = 0; g = '{d1, d2, d3};
    if (ph < 2 && !valid3(d1, d2, d3)) q_rej.push_back(c + 1);
    else if (ph == 0) begin
      ans = g; m_set = 1; ph = 1;
    end else if (ph == 1) begin
      a = 0; hits = 0;
      for (int i = 0; i < 3; i++) begin
        if (g[i] == ans[i]) a++;
        if (g[i] inside {ans[0], ans[1], ans[2]}) hits++;
      end
      m_tries = m_tries < 15 ? m_tries + 1 : 15;
      m_a = a; m_b = hits - a; busy_exp = 4;
      q_sc.push_back('{a, hits - a, m_tries, c + 5});
      if (a == 3) begin m_win = 1; ph = 2; end
      else if (m_tries == MT) begin m_lose = 1; ph = 2; end
    end
    busy = 0; lim = hold > 8 ? hold : 8;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (i == hold) iNumRdy = 1'b0;
      busy += int'(oBusy);
    end
    chk("busy_cycles", busy, busy_exp);
    chk("pending_score", q_sc.size(), 0);
    chk("pending_reject", q_rej.size(), 0);
    check_outs();
  endtask
  task automatic new_game();
    @(negedge clk); iNew = 1'b1;
    @(negedge clk); iNew = 1'b0;
    ref_clear();
    check_outs();
  endtask
  always @(negedge clk) if (reset) begin
    if (oScoreVld) begin
      if (q_sc.size() == 0) chk("unexpected_score", 1, 0);
      else begin
        mon_e = q_sc.pop_front();
        chk("score_A", oA, mon_e.a);
        chk("score_B", oB, mon_e.b);
        chk("score_tries", oTries, mon_e.t);
        chk("score_cycle", cyc, mon_e.c);
        chk("win_not_yet", oWin, 0);
      end
    end
    if (oReject) begin
      if (q_rej.size() == 0) chk("unexpected_reject", 1, 0);
      else begin
        mon_r = q_rej.pop_front();
        chk("reject_cycle", cyc, mon_r);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "time limit");
  end
  initial begin
    int d[3];
    int r;
    ref_clear();
    repeat (3) @(negedge clk);
    check_outs();
    chk("reset_busy", oBusy, 0);
    chk("reset_vld", oScoreVld, 0);
    chk("reset_rej", oReject, 0);
    reset = 1'b1;
    entry(1, 2, 3, 1); entry(3, 2, 1, 1);
    new_game();
    entry(4, 5, 6, 1); entry(4, 5, 6, 1); entry(1, 2, 3, 2);
    new_game();
    entry(1, 2, 3, 1); entry(1, 1, 2, 1); entry(1, 2, 10, 1);
    entry(4, 5, 6, 20); entry(3, 1, 2, 2);
    new_game();
    entry(7, 8, 9, 1); entry(0, 1, 2, 1); entry(9, 8, 7, 1);
    new_game();
    entry(2, 4, 6, 1);
    @(negedge clk); iNum1 = 4'd6; iNum2 = 4'd4; iNum3 = 4'd2; iNumRdy = 1'b1;
    @(negedge clk); iNumRdy = 1'b0;
    @(negedge clk); chk("busy_cmp1", oBusy, 1); iNew = 1'b1;
    @(negedge clk); iNew = 1'b0; ref_clear(); check_outs();
    repeat (8) @(negedge clk);
    chk("abort_busy", oBusy, 0);
    chk("abort_vld", q_sc.size(), 0);
    @(negedge clk); iNum1 = 4'd5; iNum2 = 4'd6; iNum3 = 4'd7; iNumRdy = 1'b1; iNew = 1'b1;
    @(negedge clk); iNew = 1'b0;
    repeat (3) @(negedge clk);
    iNumRdy = 1'b0;
    @(negedge clk); check_outs();
    entry(5, 6, 7, 1); entry(1, 2, 3, 1);
    @(negedge clk); iNum1 = 4'd7; iNum2 = 4'd6; iNum3 = 4'd5; iNumRdy = 1'b1;
    @(negedge clk); iNumRdy = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("busy_cmp2", oBusy, 1);
    #2 reset = 1'b0;
    #1 ref_clear(); check_outs();
    chk("arst_busy", oBusy, 0);
    chk("arst_vld", oScoreVld, 0);
    chk("arst_rej", oReject, 0);
    @(negedge clk); reset = 1'b1;
    for (int g = 0; g < 8; g++) begin
      new_game();
      rand_valid(d);
      entry(d[0], d[1], d[2], $urandom_range(1, 3));
      for (int k = 0; k < 4; k++) begin
        r = $urandom_range(9);
        if (r < 2) entry($urandom_range(11), $urandom_range(11), $urandom_range(11), 1);
        else if (r < 4) entry(ans[0], ans[1], ans[2], $urandom_range(1, 3));
        else begin
          rand_valid(d);
          entry(d[0], d[1], d[2], $urandom_range(1, 3));
        end
      end
    end
    chk("queues_empty", q_sc.size() + q_rej.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Round controller and scorer for the three-digit guessing game ("a A b B" display). It latches the secret answer from the first valid keypad entry. Each later valid entry is scored sequentially against the answer, and the block tracks attempts and win/lose. Its outputs (answer-set flag, A/B counts, status) feed the VGA text overlay.

## Interface
- MAX_TRIES, 8, guesses allowed before loss (1..15)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- iNum1, iNum2, iNum3  in  4 each  keypad digits, leftmost first
- iNumRdy  in  1  entry-ready level from keypad; one entry per rising edge
- iNew  in  1  one-cycle restart request
- oAnsSet  out  1  answer latched (display "flag")
- oA, oB  out  2 each  last score: right digit/right place, right digit/wrong place
- oScoreVld  out  1  one-cycle pulse when oA/oB update
- oReject  out  1  one-cycle pulse on an invalid entry
- oTries  out  4  scored guesses this game
- oBusy  out  1  scoring in progress
- oWin, oLose  out  1 each  game-over status, held

## Operation
- States:
  - SETUP: awaits answer.
  - WAIT: awaits guess.
  - CMP0, CMP1, CMP2: score digit k.
  - DONE: publish score.
  - WIN, LOSE.
- Entry event: iNumRdy high while its registered copy is low. Holding iNumRdy high yields exactly one event.
- Valid entry: every digit ≤ 9 and all three pairwise distinct. An invalid entry in SETUP or WAIT gives an oReject pulse, with no other state change.
- SETUP + valid event: latch answer, set oAnsSet, go to WAIT.
- WAIT + valid event: latch guess, clear internal A/B accumulators, go to CMP0.
- CMPk: if guess[k] == ans[k], A += 1. Otherwise, if guess[k] equals ans[j] for any j ≠ k, B += 1. Accumulators are 2-bit and never exceed 3. CMP0 → CMP1 → CMP2 → DONE.
- DONE: copy accumulators to oA/oB, pulse oScoreVld, increment oTries (saturates at 15). Next state:
  - A == 3 → WIN.
  - Else tries after increment == MAX_TRIES → LOSE.
  - Else → WAIT.
- Entry events during CMPx, DONE, WIN or LOSE are dropped; no oReject.
- WIN and LOSE hold until iNew.
- iNew in any state has priority over everything else. Next cycle is SETUP with:
  - answer, oA, oB and oTries cleared;
  - oAnsSet, oWin and oLose low;
  - any entry event in the same cycle dropped.

## Timing
- Reset values: every output 0; state SETUP; answer, guess and accumulators 0; iNumRdy history register 0.
- Event accepted at clock edge t:
  - CMP0, CMP1, CMP2 occupy the cycles after edges t, t+1, t+2.
  - DONE follows edge t+3.
  - Updated oA/oB/oTries and the oScoreVld pulse are visible in the cycle after edge t+4.
  - oWin/oLose assert one cycle later.
- oBusy is high exactly while in CMP0–DONE (4 cycles).
- Throughput: at most one guess per 5 cycles; keypad edges are far slower.
- oReject is visible in the cycle after the accepting edge.
- oA/oB hold their values between oScoreVld pulses.
- Reset asserted mid-CMP: immediate return to reset values, no score published.

## Structure
- Package game_pkg:
  - state enumeration;
  - DIGIT_W = 4;
  - DIGIT_MAX = 9;
  - NUM_DIGITS = 3.
- Sub-module entry_validator: combinational range and distinct-digit check on three digits, output valid. It is instantiated once and shared by the SETUP and WAIT paths.
- Top contains the edge detector, FSM, answer/guess registers, digit-index compare and output registers.

## Test plan
- Answer 1,2,3; guess 3,2,1 → oScoreVld 5 cycles after the edge, oA=1, oB=2, oTries=1.
- Answer 4,5,6; guess 4,5,6 → oA=3, oB=0, oWin=1 next cycle. A further entry is ignored and oTries stays 1.
- Answer 1,2,3; guesses 1,1,2 then 1,2,10 → oReject pulse each time, oTries=0, state stays WAIT.
- MAX_TRIES=2, answer 7,8,9, guesses 0,1,2 and 9,8,7 → oA=0/oB=0, then oA=1/oB=2, then oLose=1, oTries=2.
- iNumRdy held high 20 cycles in WAIT → exactly one score. iNew pulsed during CMP1 → no oScoreVld; SETUP with all outputs 0.
- iNew and an iNumRdy rising edge in the same cycle in SETUP → oAnsSet stays 0. Asynchronous reset mid-CMP2 → all outputs 0 immediately.
